change_dispenser: RTL and testbench



---
 rtl/change_dispenser.sv | 148 ++++++++++++++
 tb/tb_change_dispenser.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: on an accepted vend request, computes total-price and pays it out
// greedily (largest denomination first), one coin per cycle, then pulses done.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   start             - vend request, sampled only while idle
//   total, price      - credit inserted and product price (W bits)
//   num_500..num_5000 - coin/note inventory counts (CW bits), sampled at acceptance
//   busy              - high while coins are being dispensed
//   coin_valid        - one coin dispensed this cycle, denomination on coin_out (one-hot)
//   change_left       - change still owed
//   done              - one-cycle pulse at the end of every transaction
//   error             - 00 ok, 01 insufficient credit, 10 cannot make exact change
module change_dispenser #(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  total,
  input  logic [W-1:0]  price,
  input  logic [CW-1:0] num_500,
  input  logic [CW-1:0] num_1000,
  input  logic [CW-1:0] num_2000,
  input  logic [CW-1:0] num_5000,
  output logic          busy,
  output logic          coin_valid,
  output logic [3:0]    coin_out,
  output logic [W-1:0]  change_left,
  output logic          done,
  output logic [1:0]    error
);

  localparam logic [W-1:0] D_500  = W'(500);
  localparam logic [W-1:0] D_1000 = W'(1000);
  localparam logic [W-1:0] D_2000 = W'(2000);
  localparam logic [W-1:0] D_5000 = W'(5000);

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_CREDIT = 2'b01;
  localparam logic [1:0] ERR_EXACT  = 2'b10;

  typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt_500, cnt_1000, cnt_2000, cnt_5000;

  // Greedy pick: largest denomination still in stock that does not exceed the change owed.
  logic [3:0]   avail_c;
  logic [3:0]   sel_c;
  logic [W-1:0] sel_amt_c;

  always_comb begin
    avail_c[0] = (cnt_500  != '0) && (D_500  <= change_left);
    avail_c[1] = (cnt_1000 != '0) && (D_1000 <= change_left);
    avail_c[2] = (cnt_2000 != '0) && (D_2000 <= change_left);
    avail_c[3] = (cnt_5000 != '0) && (D_5000 <= change_left);
    sel_c      = 4'b0000;
    sel_amt_c  = '0;
    if (avail_c[3]) begin
      sel_c     = 4'b1000;
      sel_amt_c = D_5000;
    end else if (avail_c[2]) begin
      sel_c     = 4'b0100;
      sel_amt_c = D_2000;
    end else if (avail_c[1]) begin
      sel_c     = 4'b0010;
      sel_amt_c = D_1000;
    end else if (avail_c[0]) begin
      sel_c     = 4'b0001;
      sel_amt_c = D_500;
    end
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      coin_valid  <= 1'b0;
      coin_out    <= 4'b0000;
      change_left <= '0;
      done        <= 1'b0;
      error       <= ERR_OK;
      cnt_500     <= '0;
      cnt_1000    <= '0;
      cnt_2000    <= '0;
      cnt_5000    <= '0;
    end else begin
      coin_valid <= 1'b0;
      coin_out   <= 4'b0000;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            cnt_500  <= num_500;
            cnt_1000 <= num_1000;
            cnt_2000 <= num_2000;
            cnt_5000 <= num_5000;
            error    <= ERR_OK;
            // Subtract only after the credit check so the difference cannot wrap.
            if (total < price) begin
              error       <= ERR_CREDIT;
              change_left <= '0;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              change_left <= total - price;
              busy        <= 1'b1;
              state       <= DISPENSE;
            end
          end
        end
        DISPENSE: begin
          if (change_left == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (sel_c != 4'b0000) begin
            coin_valid  <= 1'b1;
            coin_out    <= sel_c;
            change_left <= change_left - sel_amt_c;
            if (sel_c[0]) cnt_500  <= cnt_500  - CW'(1);
            if (sel_c[1]) cnt_1000 <= cnt_1000 - CW'(1);
            if (sel_c[2]) cnt_2000 <= cnt_2000 - CW'(1);
            if (sel_c[3]) cnt_5000 <= cnt_5000 - CW'(1);
          end else begin
            // No denomination fits: keep the residue on change_left and report.
            error <= ERR_EXACT;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser against a greedy payout model.
module tb_change_dispenser;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 8;

  logic          clock;
  logic          reset;
  logic          start;
  logic [W-1:0]  total;
  logic [W-1:0]  price;
  logic [CW-1:0] num_500, num_1000, num_2000, num_5000;
  logic          busy;
  logic          coin_valid;
  logic [3:0]    coin_out;
  logic [W-1:0]  change_left;
  logic          done;
  logic [1:0]    error;

  change_dispenser #(.W(W), .CW(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .total      (total),
    .price      (price),
    .num_500    (num_500),
    .num_1000   (num_1000),
    .num_2000   (num_2000),
    .num_5000   (num_5000),
    .busy       (busy),
    .coin_valid (coin_valid),
    .coin_out   (coin_out),
    .change_left(change_left),
    .done       (done),
    .error      (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [3:0] onehot(input int d);
    case (d)
      500:     return 4'b0001;
      1000:    return 4'b0010;
      2000:    return 4'b0100;
      5000:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // Reference model outputs
  int exp_coins[$];
  int exp_res;
  int exp_err;
  int exp_short;

  task automatic model(input int t, input int p, input int c500, input int c1000,
                       input int c2000, input int c5000);
    int dv[4];
    int av[4];
    int rem;
    bit found;
    dv = '{5000, 2000, 1000, 500};
    av = '{c5000, c2000, c1000, c500};
    exp_coins.delete();
    exp_err   = 0;
    exp_short = 0;
    if (t < p) begin
      exp_err   = 1;
      exp_short = 1;
      exp_res   = 0;
      return;
    end
    rem = t - p;
    while (rem > 0) begin
      found = 0;
      for (int j = 0; j < 4; j++) begin
        if (!found && av[j] > 0 && dv[j] <= rem) begin
          exp_coins.push_back(dv[j]);
          av[j]--;
          rem -= dv[j];
          found = 1;
        end
      end
      if (!found) begin
        exp_err = 2;
        break;
      end
    end
    exp_res = rem;
  endtask

  task automatic scramble_inputs();
    start    = 1'($urandom_range(0, 1));
    num_500  = CW'($urandom_range(0, 9));
    num_1000 = CW'($urandom_range(0, 9));
    num_2000 = CW'($urandom_range(0, 9));
    num_5000 = CW'($urandom_range(0, 9));
    total    = W'($urandom_range(0, 20000));
    price    = W'($urandom_range(0, 20000));
  endtask

  // Called at a negedge while idle; returns at a negedge back in idle with start low.
  task automatic run_txn(input int t, input int p, input int c500, input int c1000,
                         input int c2000, input int c5000);
    int rem;
    model(t, p, c500, c1000, c2000, c5000);
    start    = 1'b1;
    total    = W'(t);
    price    = W'(p);
    num_500  = CW'(c500);
    num_1000 = CW'(c1000);
    num_2000 = CW'(c2000);
    num_5000 = CW'(c5000);
    @(negedge clock);
    scramble_inputs();
    if (exp_short != 0) begin
      check("short_done", 32'(done), 1);
      check("short_err", 32'(error), 1);
      check("short_change", 32'(change_left), 0);
      check("short_busy", 32'(busy), 0);
      check("short_coin", 32'(coin_valid), 0);
    end else begin
      rem = t - p;
      check("acc_busy", 32'(busy), 1);
      check("acc_coin", 32'(coin_valid), 0);
      check("acc_change", 32'(change_left), 32'(rem));
      check("acc_err", 32'(error), 0);
      check("acc_done", 32'(done), 0);
      foreach (exp_coins[i]) begin
        @(negedge clock);
        scramble_inputs();
        rem -= exp_coins[i];
        check("coin_valid", 32'(coin_valid), 1);
        check("coin_out", 32'(coin_out), 32'(onehot(exp_coins[i])));
        check("coin_change", 32'(change_left), 32'(rem));
        check("coin_busy", 32'(busy), 1);
        check("coin_done", 32'(done), 0);
      end
      @(negedge clock);
      scramble_inputs();
      check("end_done", 32'(done), 1);
      check("end_coin", 32'(coin_valid), 0);
      check("end_coin_out", 32'(coin_out), 0);
      check("end_busy", 32'(busy), 0);
      check("end_err", 32'(error), 32'(exp_err));
      check("end_res", 32'(change_left), 32'(exp_res));
    end
    @(negedge clock);
    start = 1'b0;
    check("idle_done", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_coin", 32'(coin_valid), 0);
    check("idle_err", 32'(error), 32'(exp_err));
  endtask

  initial begin
    int t, p;
    reset    = 1'b1;
    start    = 1'b1;
    total    = W'(9000);
    price    = W'(500);
    num_500  = CW'(5);
    num_1000 = CW'(5);
    num_2000 = CW'(5);
    num_5000 = CW'(5);
    @(negedge clock);
    @(negedge clock);
    check("rst_busy", 32'(busy), 0);
    check("rst_coin", 32'(coin_valid), 0);
    check("rst_coin_out", 32'(coin_out), 0);
    check("rst_change", 32'(change_left), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(error), 0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check("post_rst_busy", 32'(busy), 0);

    // Directed scenarios
    run_txn(3500, 1500, 5, 5, 5, 5);
    run_txn(9000, 500, 2, 2, 0, 1);
    run_txn(1000, 1500, 5, 5, 5, 5);
    run_txn(5000, 1500, 0, 1, 1, 0);
    run_txn(2000, 2000, 1, 1, 1, 1);
    run_txn(1700, 1000, 3, 3, 3, 3);

    // Reset right after the first coin aborts the transaction
    start    = 1'b1;
    total    = W'(9000);
    price    = W'(500);
    num_500  = CW'(2);
    num_1000 = CW'(2);
    num_2000 = CW'(0);
    num_5000 = CW'(1);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("abort_first_coin", 32'(coin_out), 32'(4'b1000));
    reset = 1'b1;
    @(negedge clock);
    check("abort_coin", 32'(coin_valid), 0);
    check("abort_done", 32'(done), 0);
    check("abort_err", 32'(error), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_change", 32'(change_left), 0);
    reset = 1'b0;
    @(negedge clock);
    check("abort_idle_coin", 32'(coin_valid), 0);
    check("abort_idle_done", 32'(done), 0);
    run_txn(9000, 500, 2, 2, 0, 1);

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      t = $urandom_range(0, 30) * 500;
      p = $urandom_range(1, 30) * 500;
      if ($urandom_range(0, 3) == 0) t += $urandom_range(0, 499);
      run_txn(t, p, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
